reg_writeback_queue: RTL and testbench

//  Write-side initiator for the 16x16 register file. Accepts execution results
//  (dest reg, data) over a valid/ready handshake and buffers them in a small FIFO.
//  It drains one entry per cycle onto the register-file write port (WriteRgAddr/WriteData).
//  It also provides bypass lookup so readers see pending writes before they commit.

---
 rtl/reg_writeback_queue.sv | 149 ++++++++++++++
 tb/tb_reg_writeback_queue.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_writeback_queue.sv
// Write-side queue for the 16x16 register file: buffers execution results and
// drains one per cycle onto the write port, with bypass lookup of pending writes.
module reg_writeback_queue #(
    parameter int DATA_WIDTH     = 16,
    parameter int REG_ADDR_WIDTH = 4,
    parameter int DEPTH          = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [REG_ADDR_WIDTH-1:0] in_addr,
    input  logic [DATA_WIDTH-1:0]     in_data,
    input  logic                      wr_stall,
    input  logic                      flush,
    output logic                      wr_en,
    output logic [REG_ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0]     wr_data,
    input  logic [REG_ADDR_WIDTH-1:0] byp_addr1,
    input  logic [REG_ADDR_WIDTH-1:0] byp_addr2,
    output logic                      byp_hit1,
    output logic                      byp_hit2,
    output logic [DATA_WIDTH-1:0]     byp_data1,
    output logic [DATA_WIDTH-1:0]     byp_data2,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [PTR_W-1:0]          head_q, head_d;
    logic [PTR_W-1:0]          tail_q, tail_d;
    logic [CNT_W-1:0]          count_q, count_d;
    logic [REG_ADDR_WIDTH-1:0] addr_mem_q [DEPTH];
    logic [REG_ADDR_WIDTH-1:0] addr_mem_d [DEPTH];
    logic [DATA_WIDTH-1:0]     data_mem_q [DEPTH];
    logic [DATA_WIDTH-1:0]     data_mem_d [DEPTH];
    logic                      wr_en_q, wr_en_d;
    logic [REG_ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0]     wr_data_q, wr_data_d;

    logic push_fire;
    logic store;
    logic pop;

    // Handshake: a transfer happens at a rising edge where in_valid && in_ready;
    // in_ready depends only on registered occupancy, never on in_valid or a pop.
    assign in_ready = (count_q < FULL_CNT);
    assign count    = count_q;
    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;

    always_comb begin
        push_fire = in_valid && in_ready && !flush;
        store     = push_fire && (in_addr != '0);
        pop       = (count_q != '0) && !wr_stall && !flush;

        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        addr_mem_d = addr_mem_q;
        data_mem_d = data_mem_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = '0;
        wr_data_d  = '0;

        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (pop) begin
                wr_en_d   = 1'b1;
                wr_addr_d = addr_mem_q[head_q];
                wr_data_d = data_mem_q[head_q];
                head_d    = head_q + PTR_W'(1);
            end
            // R0 writes complete the handshake but are never stored.
            if (store) begin
                addr_mem_d[tail_q] = in_addr;
                data_mem_d[tail_q] = in_data;
                tail_d             = tail_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(store) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            addr_mem_q <= '{default: '0};
            data_mem_q <= '{default: '0};
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            addr_mem_q <= addr_mem_d;
            data_mem_q <= data_mem_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

    logic [REG_ADDR_WIDTH-1:0] byp_addr_arr [2];
    logic                      byp_hit_arr  [2];
    logic [DATA_WIDTH-1:0]     byp_data_arr [2];
    logic [PTR_W-1:0]          byp_idx;

    assign byp_addr_arr[0] = byp_addr1;
    assign byp_addr_arr[1] = byp_addr2;
    assign byp_hit1        = byp_hit_arr[0];
    assign byp_hit2        = byp_hit_arr[1];
    assign byp_data1       = byp_data_arr[0];
    assign byp_data2       = byp_data_arr[1];

    // Scan oldest-to-youngest so later matches override: youngest FIFO entry wins,
    // and the write-port register only answers when no FIFO entry matches.
    always_comb begin
        byp_idx = '0;
        for (int p = 0; p < 2; p++) begin
            byp_hit_arr[p]  = 1'b0;
            byp_data_arr[p] = '0;
            if (wr_en_q && (wr_addr_q == byp_addr_arr[p])) begin
                byp_hit_arr[p]  = 1'b1;
                byp_data_arr[p] = wr_data_q;
            end
            for (int i = 0; i < DEPTH; i++) begin
                byp_idx = head_q + PTR_W'(i);
                if ((CNT_W'(i) < count_q) && (addr_mem_q[byp_idx] == byp_addr_arr[p])) begin
                    byp_hit_arr[p]  = 1'b1;
                    byp_data_arr[p] = data_mem_q[byp_idx];
                end
            end
            if (byp_addr_arr[p] == '0) begin
                byp_hit_arr[p]  = 1'b0;
                byp_data_arr[p] = '0;
            end
        end
    end

endmodule

// File: tb/tb_reg_writeback_queue.sv
// Bench for reg_writeback_queue: directed scenarios plus a randomized run
// against a queue-based model of the pending-write list.
module tb_reg_writeback_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_addr;
  logic [15:0] in_data;
  logic        wr_stall;
  logic        flush;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic [3:0]  byp_addr1;
  logic [3:0]  byp_addr2;
  logic        byp_hit1;
  logic        byp_hit2;
  logic [15:0] byp_data1;
  logic [15:0] byp_data2;
  logic [2:0]  count;

  int n_vec = 0;
  int n_err = 0;

  // model state: pending entries oldest-first, and the write-port register
  logic [19:0] mq[$];
  logic        m_wr_en;
  logic [3:0]  m_wr_addr;
  logic [15:0] m_wr_data;
  logic [19:0] exp_q[$];

  reg_writeback_queue dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_data(in_data), .wr_stall(wr_stall), .flush(flush),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .byp_addr1(byp_addr1), .byp_addr2(byp_addr2),
    .byp_hit1(byp_hit1), .byp_hit2(byp_hit2),
    .byp_data1(byp_data1), .byp_data2(byp_data2), .count(count)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic [3:0] a, input logic [15:0] d,
                       input logic s, input logic f);
    in_valid = v;
    in_addr  = a;
    in_data  = d;
    wr_stall = s;
    flush    = f;
  endtask

  function automatic void model_reset();
    mq.delete();
    m_wr_en   = 1'b0;
    m_wr_addr = '0;
    m_wr_data = '0;
  endfunction

  function automatic void model_edge();
    logic        ready;
    logic [19:0] head;
    ready = (mq.size() < 4);
    if (flush) begin
      model_reset();
      return;
    end
    if (mq.size() > 0 && !wr_stall) begin
      head      = mq.pop_front();
      m_wr_en   = 1'b1;
      m_wr_addr = head[19:16];
      m_wr_data = head[15:0];
    end else begin
      m_wr_en   = 1'b0;
      m_wr_addr = '0;
      m_wr_data = '0;
    end
    if (in_valid && ready && in_addr != 4'd0) mq.push_back({in_addr, in_data});
  endfunction

  function automatic logic [16:0] m_byp(input logic [3:0] a);
    if (a == 4'd0) return 17'd0;
    for (int i = mq.size() - 1; i >= 0; i--)
      if (mq[i][19:16] == a) return {1'b1, mq[i][15:0]};
    if (m_wr_en && m_wr_addr == a) return {1'b1, m_wr_data};
    return 17'd0;
  endfunction

  // one rising edge, with the model advanced on the same edge; returns at negedge
  task automatic tick();
    @(posedge clk);
    if (rst) model_edge();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive(1'b1, 4'd3, 16'h1234, 1'b0, 1'b0);
    byp_addr1 = '0;
    byp_addr2 = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    n_vec++; if (wr_en !== 1'b0) begin n_err++; $display("FAIL reset_wr_en: got %0b want 0", wr_en); end
    n_vec++; if (wr_addr !== 4'd0) begin n_err++; $display("FAIL reset_wr_addr: got %0d want 0", wr_addr); end
    n_vec++; if (wr_data !== 16'd0) begin n_err++; $display("FAIL reset_wr_data: got %0d want 0", wr_data); end
    n_vec++; if (count !== 3'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", count); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
    drive(1'b0, 4'd0, 16'd0, 1'b0, 1'b0);
    rst = 1'b1;
  endtask

  task automatic test_back_to_back();
    logic [3:0]  pa [3];
    logic [15:0] pd [3];
    logic        ee [5];
    logic [3:0]  ea [5];
    logic [15:0] ed [5];
    pa = '{4'd3, 4'd5, 4'd7};
    pd = '{16'd30, 16'd50, 16'd70};
    ee = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    ea = '{4'd0, 4'd3, 4'd5, 4'd7, 4'd0};
    ed = '{16'd0, 16'd30, 16'd50, 16'd70, 16'd0};
    for (int k = 0; k < 5; k++) begin
      if (k < 3) drive(1'b1, pa[k], pd[k], 1'b0, 1'b0);
      else drive(1'b0, 4'd0, 16'd0, 1'b0, 1'b0);
      tick();
      n_vec++; if (wr_en !== ee[k]) begin n_err++; $display("FAIL b2b_wr_en[%0d]: got %0b want %0b", k, wr_en, ee[k]); end
      n_vec++; if (wr_addr !== ea[k]) begin n_err++; $display("FAIL b2b_wr_addr[%0d]: got %0d want %0d", k, wr_addr, ea[k]); end
      n_vec++; if (wr_data !== ed[k]) begin n_err++; $display("FAIL b2b_wr_data[%0d]: got %0d want %0d", k, wr_data, ed[k]); end
    end
  endtask

  task automatic test_full_stall();
    logic [15:0] d;
    logic [19:0] e;
    for (int k = 0; k < 5; k++) begin
      d = 16'($urandom_range(1, 65535));
      drive(1'b1, 4'(k + 1), d, 1'b1, 1'b0);
      #1;
      n_vec++; if (in_ready !== (k < 4)) begin n_err++; $display("FAIL stall_in_ready[%0d]: got %0b want %0b", k, in_ready, (k < 4)); end
      if (k < 4) exp_q.push_back({4'(k + 1), d});
      tick();
    end
    n_vec++; if (count !== 3'd4) begin n_err++; $display("FAIL stall_count_full: got %0d want 4", count); end
    drive(1'b0, 4'd0, 16'd0, 1'b0, 1'b0);
    for (int c = 0; c < 6; c++) begin
      tick();
      if (wr_en) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_err++; $display("FAIL stall_extra_write: got %0d/%0d want none", wr_addr, wr_data);
        end else begin
          e = exp_q.pop_front();
          n_vec++; if ({wr_addr, wr_data} !== e) begin n_err++; $display("FAIL stall_drain: got %0d/%0d want %0d/%0d", wr_addr, wr_data, e[19:16], e[15:0]); end
        end
      end
    end
    n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL stall_missing_writes: got %0d left want 0", exp_q.size()); end
    n_vec++; if (count !== 3'd0) begin n_err++; $display("FAIL stall_count_empty: got %0d want 0", count); end
    exp_q.delete();
  endtask

  task automatic test_r0_discard();
    drive(1'b1, 4'd0, 16'd123, 1'b0, 1'b0);
    tick();
    n_vec++; if (count !== 3'd0) begin n_err++; $display("FAIL r0_count: got %0d want 0", count); end
    drive(1'b1, 4'd2, 16'd20, 1'b0, 1'b0);
    tick();
    n_vec++; if (wr_en !== 1'b0) begin n_err++; $display("FAIL r0_wr_en: got %0b want 0", wr_en); end
    n_vec++; if (count !== 3'd1) begin n_err++; $display("FAIL r0_count2: got %0d want 1", count); end
    drive(1'b0, 4'd0, 16'd0, 1'b0, 1'b0);
    tick();
    n_vec++; if ({wr_en, wr_addr, wr_data} !== {1'b1, 4'd2, 16'd20}) begin n_err++; $display("FAIL r0_write: got %0b/%0d/%0d want 1/2/20", wr_en, wr_addr, wr_data); end
    tick();
    n_vec++; if (wr_en !== 1'b0) begin n_err++; $display("FAIL r0_after: got %0b want 0", wr_en); end
  endtask

  task automatic test_bypass();
    drive(1'b1, 4'd4, 16'd40, 1'b1, 1'b0);
    tick();
    drive(1'b1, 4'd4, 16'd44, 1'b1, 1'b0);
    tick();
    drive(1'b0, 4'd0, 16'd0, 1'b1, 1'b0);
    byp_addr1 = 4'd4;
    byp_addr2 = 4'd0;
    #1;
    n_vec++; if ({byp_hit1, byp_data1} !== {1'b1, 16'd44}) begin n_err++; $display("FAIL byp_young: got %0b/%0d want 1/44", byp_hit1, byp_data1); end
    n_vec++; if ({byp_hit2, byp_data2} !== {1'b0, 16'd0}) begin n_err++; $display("FAIL byp_r0: got %0b/%0d want 0/0", byp_hit2, byp_data2); end
    byp_addr2 = 4'd4;
    #1;
    n_vec++; if ({byp_hit2, byp_data2} !== {1'b1, 16'd44}) begin n_err++; $display("FAIL byp_port2: got %0b/%0d want 1/44", byp_hit2, byp_data2); end
    byp_addr2 = 4'd9;
    drive(1'b0, 4'd0, 16'd0, 1'b0, 1'b0);
    tick();
    n_vec++; if ({byp_hit1, byp_data1} !== {1'b1, 16'd44}) begin n_err++; $display("FAIL byp_fifo_over_wr: got %0b/%0d want 1/44", byp_hit1, byp_data1); end
    n_vec++; if (byp_hit2 !== 1'b0) begin n_err++; $display("FAIL byp_miss: got %0b want 0", byp_hit2); end
    tick();
    n_vec++; if ({byp_hit1, byp_data1} !== {1'b1, 16'd44}) begin n_err++; $display("FAIL byp_wr_reg: got %0b/%0d want 1/44", byp_hit1, byp_data1); end
    tick();
    n_vec++; if ({byp_hit1, byp_data1} !== {1'b0, 16'd0}) begin n_err++; $display("FAIL byp_gone: got %0b/%0d want 0/0", byp_hit1, byp_data1); end
    byp_addr1 = 4'd0;
    byp_addr2 = 4'd0;
  endtask

  task automatic test_full_pop();
    logic [3:0] ea [3];
    ea = '{4'd10, 4'd11, 4'd13};
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 4'(8 + k), 16'(100 * (8 + k)), 1'b1, 1'b0);
      tick();
    end
    drive(1'b1, 4'd12, 16'd1200, 1'b0, 1'b0);
    #1;
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL fullpop_ready: got %0b want 0", in_ready); end
    tick();
    n_vec++; if (count !== 3'd3) begin n_err++; $display("FAIL fullpop_count: got %0d want 3", count); end
    n_vec++; if ({wr_en, wr_addr} !== {1'b1, 4'd8}) begin n_err++; $display("FAIL fullpop_wr: got %0b/%0d want 1/8", wr_en, wr_addr); end
    drive(1'b1, 4'd13, 16'd1300, 1'b0, 1'b0);
    #1;
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL fullpop_ready3: got %0b want 1", in_ready); end
    tick();
    n_vec++; if (count !== 3'd3) begin n_err++; $display("FAIL fullpop_count_same: got %0d want 3", count); end
    n_vec++; if (wr_addr !== 4'd9) begin n_err++; $display("FAIL fullpop_wr9: got %0d want 9", wr_addr); end
    drive(1'b0, 4'd0, 16'd0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick();
      n_vec++; if ({wr_en, wr_addr} !== {1'b1, ea[k]}) begin n_err++; $display("FAIL fullpop_drain[%0d]: got %0b/%0d want 1/%0d", k, wr_en, wr_addr, ea[k]); end
    end
    tick();
    n_vec++; if ({wr_en, count} !== {1'b0, 3'd0}) begin n_err++; $display("FAIL fullpop_end: got %0b/%0d want 0/0", wr_en, count); end
  endtask

  task automatic test_flush();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 4'(k + 1), 16'(k + 500), 1'b1, 1'b0);
      tick();
    end
    drive(1'b1, 4'd6, 16'd66, 1'b0, 1'b1);
    tick();
    n_vec++; if (count !== 3'd0) begin n_err++; $display("FAIL flush_count: got %0d want 0", count); end
    n_vec++; if (wr_en !== 1'b0) begin n_err++; $display("FAIL flush_wr_en: got %0b want 0", wr_en); end
    drive(1'b0, 4'd0, 16'd0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick();
      n_vec++; if ({wr_en, count} !== {1'b0, 3'd0}) begin n_err++; $display("FAIL flush_quiet[%0d]: got %0b/%0d want 0/0", k, wr_en, count); end
    end
  endtask

  task automatic test_reset_mid_drain();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 4'(k + 5), 16'(k + 700), 1'b1, 1'b0);
      tick();
    end
    drive(1'b0, 4'd0, 16'd0, 1'b0, 1'b0);
    tick();
    n_vec++; if ({wr_en, wr_addr} !== {1'b1, 4'd5}) begin n_err++; $display("FAIL rstmid_pre: got %0b/%0d want 1/5", wr_en, wr_addr); end
    #2 rst = 1'b0;
    #1;
    model_reset();
    n_vec++; if ({wr_en, wr_addr, wr_data} !== 21'd0) begin n_err++; $display("FAIL rstmid_wr: got %0b/%0d/%0d want 0/0/0", wr_en, wr_addr, wr_data); end
    n_vec++; if (count !== 3'd0) begin n_err++; $display("FAIL rstmid_count: got %0d want 0", count); end
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      n_vec++; if (wr_en !== 1'b0) begin n_err++; $display("FAIL rstmid_after[%0d]: got %0b want 0", k, wr_en); end
    end
  endtask

  task automatic test_random();
    logic [16:0] b1;
    logic [16:0] b2;
    for (int c = 0; c < 400; c++) begin
      drive(($urandom_range(0, 9) < 7), 4'($urandom_range(0, 7)), 16'($urandom),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 31) == 0));
      byp_addr1 = 4'($urandom_range(0, 7));
      byp_addr2 = 4'($urandom_range(0, 7));
      #1;
      b1 = m_byp(byp_addr1);
      b2 = m_byp(byp_addr2);
      n_vec++; if (in_ready !== (mq.size() < 4)) begin n_err++; $display("FAIL rnd_ready[%0d]: got %0b want %0b", c, in_ready, (mq.size() < 4)); end
      n_vec++; if (count !== 3'(mq.size())) begin n_err++; $display("FAIL rnd_count[%0d]: got %0d want %0d", c, count, mq.size()); end
      n_vec++; if ({wr_en, wr_addr, wr_data} !== {m_wr_en, m_wr_addr, m_wr_data}) begin
        n_err++; $display("FAIL rnd_wr[%0d]: got %0b/%0d/%0h want %0b/%0d/%0h", c, wr_en, wr_addr, wr_data, m_wr_en, m_wr_addr, m_wr_data);
      end
      n_vec++; if ({byp_hit1, byp_data1} !== b1) begin n_err++; $display("FAIL rnd_byp1[%0d]: got %0b/%0h want %0b/%0h", c, byp_hit1, byp_data1, b1[16], b1[15:0]); end
      n_vec++; if ({byp_hit2, byp_data2} !== b2) begin n_err++; $display("FAIL rnd_byp2[%0d]: got %0b/%0h want %0b/%0h", c, byp_hit2, byp_data2, b2[16], b2[15:0]); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_full_stall();
    test_r0_discard();
    test_bypass();
    test_full_pop();
    test_flush();
    test_reset_mid_drain();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
